// File: rtl/banked_cart_mapper_pkg.sv
// Shared constants and types for the banked cartridge mapper and its reset sequencer.
// Constants only; no logic.
package banked_cart_pkg;

  localparam logic [1:0] REG_ROM   = 2'b00;
  localparam logic [1:0] REG_RAM   = 2'b01;
  localparam logic [1:0] REG_NVRAM = 2'b10;

  // Register offsets, decoded on vic_addr[9:4]
  localparam logic [5:0] OFS_BANK = 6'h00;
  localparam logic [5:0] OFS_CTRL = 6'h10;
  localparam logic [5:0] OFS_TRIG = 6'h20;

  localparam int CTRL_NVRAM_WR = 0;
  localparam int CTRL_RAM_WP   = 1;
  localparam int CTRL_LOCK     = 2;
  localparam int CTRL_IMM      = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HOLDOFF
  } seq_state_t;

endpackage

// File: rtl/banked_cart_mapper_soft_reset_seq.sv
// Commit/soft-reset sequencer: commit is same-cycle with the trigger, then a RESET_PULSE
// reset pulse and HOLDOFF busy cycles; the caller must drop triggers while o_busy is high.
module soft_reset_seq
  import banked_cart_pkg::*;
#(
  parameter int RESET_PULSE = 32,
  parameter int HOLDOFF     = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_trigger,
  output logic o_commit,
  output logic o_soft_reset,
  output logic o_busy
);

  localparam int MAXC  = (RESET_PULSE > HOLDOFF) ? RESET_PULSE : HOLDOFF;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  assign o_commit = i_trigger && (r_state == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      o_soft_reset <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_trigger) begin
            r_state      <= ST_PULSE;
            r_cnt        <= CNT_W'(RESET_PULSE - 1);
            o_soft_reset <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            o_soft_reset <= 1'b0;
            if (HOLDOFF == 0) begin
              r_state <= ST_IDLE;
              o_busy  <= 1'b0;
            end else begin
              r_state <= ST_HOLDOFF;
              r_cnt   <= CNT_W'(HOLDOFF - 1);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          o_soft_reset <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/banked_cart_mapper.sv
// VIC-20 banked cart mapper: per-window bank registers, combinational address map, no backpressure.
// Optional MAPPER_LOCK_EN makes ctrl bit2 a sticky lock of all register writes until reset.
module banked_cart_mapper
  import banked_cart_pkg::*;
#(
  parameter int NUM_WIN     = 4,
  parameter int BANK_W      = 7,
  parameter int ADDR_W      = BANK_W + 15,
  parameter int RESET_PULSE = 32,
  parameter int HOLDOFF     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [15:0]        i_vic_addr,
  input  logic               i_vic_wr_n,
  input  logic               i_vic_io2_sel,
  input  logic               i_vic_io3_sel,
  input  logic               i_vic_ram123_sel,
  input  logic [NUM_WIN-1:0] i_vic_blk_sel,
  input  logic [7:0]         i_vic_data,
  output logic [ADDR_W-1:0]  o_mc_addr,
  output logic               o_mc_wr_n,
  output logic               o_mc_nvram_sel,
  output logic               o_mc_soft_reset,
  output logic               o_mc_busy
);

  logic [7:0] r_shadow [NUM_WIN];
  logic [7:0] r_live   [NUM_WIN];
  logic       r_bank_ena;
  logic       r_prev;
  logic [3:0] r_ctrl;

  logic        w_wr_req, w_wstb, w_wr_ok, w_lock;
  logic [5:0]  w_reg_ofs;
  logic        w_bank_hit, w_ctrl_hit, w_trig, w_commit;
  logic [3:0]  w_bank_idx;
  logic [3:0]  w_ctrl_next;
  logic        w_win_hit, w_ram_mode, w_nvram;
  logic [1:0]  w_win_idx;
  logic [7:0]  w_cur;
  logic [BANK_W-1:0] w_bank;
  logic [ADDR_W-1:0] w_addr;
  logic        w_unused;

  assign w_unused = ^i_vic_addr[15:13];

  // Edge-detected strobe: a write held across many cycles acts once
  assign w_wr_req   = i_vic_io3_sel & ~i_vic_wr_n;
  assign w_wstb     = w_wr_req & ~r_prev;
  assign w_lock     = r_ctrl[CTRL_LOCK];
  assign w_wr_ok    = w_wstb & ~o_mc_busy & ~w_lock;
  assign w_reg_ofs  = i_vic_addr[9:4];
  assign w_bank_idx = w_reg_ofs[3:0];
  assign w_bank_hit = w_wr_ok & (w_reg_ofs[5:4] == OFS_BANK[5:4]);
  assign w_ctrl_hit = w_wr_ok & (w_reg_ofs == OFS_CTRL);
  assign w_trig     = w_wr_ok & (w_reg_ofs == OFS_TRIG);

`ifdef MAPPER_LOCK_EN
  assign w_ctrl_next = i_vic_data[3:0];
`else
  assign w_ctrl_next = {i_vic_data[CTRL_IMM], 1'b0, i_vic_data[CTRL_RAM_WP], i_vic_data[CTRL_NVRAM_WR]};
`endif

  soft_reset_seq #(
    .RESET_PULSE (RESET_PULSE),
    .HOLDOFF     (HOLDOFF)
  ) u_seq (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_trigger    (w_trig),
    .o_commit     (w_commit),
    .o_soft_reset (o_mc_soft_reset),
    .o_busy       (o_mc_busy)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev     <= 1'b0;
      r_bank_ena <= 1'b0;
      r_ctrl     <= '0;
      for (int w = 0; w < NUM_WIN; w++) begin
        r_shadow[w] <= 8'h00;
        r_live[w]   <= 8'h00;
      end
    end else begin
      r_prev <= w_wr_req;
      if (w_ctrl_hit) r_ctrl <= w_ctrl_next;
      if (w_commit) begin
        r_bank_ena <= 1'b1;
        for (int w = 0; w < NUM_WIN; w++) r_live[w] <= r_shadow[w];
      end
      for (int w = 0; w < NUM_WIN; w++) begin
        if (w_bank_hit && (w_bank_idx == 4'(w))) begin
          r_shadow[w] <= i_vic_data;
          if (r_ctrl[CTRL_IMM]) r_live[w] <= i_vic_data;
        end
      end
    end
  end

  // Lowest selected window wins
  always_comb begin
    w_win_idx = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (i_vic_blk_sel[w]) w_win_idx = 2'(w);
    end
  end

  assign w_win_hit  = i_reset_n & (|i_vic_blk_sel);
  assign w_cur      = r_live[w_win_idx];
  assign w_ram_mode = r_bank_ena & w_cur[7];
  assign w_bank     = r_bank_ena ? w_cur[BANK_W-1:0] : {BANK_W{1'b1}};
  assign w_nvram    = i_reset_n & (i_vic_ram123_sel | i_vic_io2_sel | i_vic_io3_sel);

  always_comb begin
    w_addr = '0;
    if (w_win_hit) begin
      w_addr[12:0] = i_vic_addr[12:0];
      if (w_ram_mode) begin
        w_addr[14:13]          = w_win_idx;
        w_addr[ADDR_W-1 -: 2]  = REG_RAM;
      end else begin
        w_addr[13 +: BANK_W]   = w_bank;
        w_addr[ADDR_W-1 -: 2]  = REG_ROM;
      end
    end else if (w_nvram) begin
      w_addr[12:0]          = i_vic_addr[12:0];
      w_addr[ADDR_W-1 -: 2] = REG_NVRAM;
    end
  end

  assign o_mc_addr      = w_addr;
  assign o_mc_nvram_sel = w_nvram;
  assign o_mc_wr_n      = ~(i_reset_n & ~i_vic_wr_n &
                            ((w_win_hit & w_ram_mode & ~r_ctrl[CTRL_RAM_WP]) |
                             (w_nvram & r_ctrl[CTRL_NVRAM_WR])));

endmodule

// File: doc/banked_cart_mapper.md
Name: banked_cart_mapper

Overview:
Parametrised VIC-20 bank-switching cartridge mapper, the successor to the single-ROM MegaCart wedge. Sits between the VIC-20 core's memory selects and SDRAM, and gives each of NUM_WIN 8K windows its own bank register. Bank writes are staged in shadow registers and committed atomically by a sequenced soft reset. Output address is region-tagged: ROM, cart RAM or NVRAM.

Parameters:
NUM_WIN, 4, number of 8K windows; window w is selected by vic_blk_sel[w] (blk1,blk2,blk3,blk5); range 1..4.
BANK_W, 7, ROM bank index width; range 1..7; ROM size is 2^BANK_W x 8K.
ADDR_W, BANK_W+15, mc_addr width, split as {region[1:0], bank[BANK_W-1:0], offset[12:0]}.
RESET_PULSE, 32, number of clk cycles mc_soft_reset is held high; must be >= 1.
HOLDOFF, 16, cycles after the pulse during which register writes are ignored; 0 is allowed.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
vic_addr  in  16  CPU address
vic_wr_n  in  1  CPU write strobe, active low
vic_io2_sel  in  1  0x9800-0x9BFF select
vic_io3_sel  in  1  0x9C00-0x9FFF select
vic_ram123_sel  in  1  0x0400-0x0FFF select
vic_blk_sel  in  NUM_WIN  window selects
vic_data  in  8  CPU write data
mc_addr  out  ADDR_W  mapped SDRAM address
mc_wr_n  out  1  qualified write, active low
mc_nvram_sel  out  1  NVRAM access
mc_soft_reset  out  1  registered CPU reset request
mc_busy  out  1  sequencer not idle

Behaviour:
- Clock and reset: single clock domain clk; reset_n is synchronous and active-low.
- Reset values on the clock edge where reset_n=0:
  - shadow and live bank registers = 8'h00.
  - bank_ena=0, ctrl=0, FSM=IDLE.
  - mc_soft_reset=0, mc_busy=0.
- While reset_n=0, combinational outputs are also forced: mc_wr_n=1, mc_nvram_sel=0, mc_addr=0.
- Write strobe:
  - wstb = vic_io3_sel & ~vic_wr_n & ~prev, where prev is the registered value of (vic_io3_sel & ~vic_wr_n).
  - A write held for many cycles therefore acts exactly once.
- Register map; full decode on vic_addr[9:4], other bits ignored:
  - 0x9C00 + 16*w: shadow bank w; bit7 = RAM mode, bits[BANK_W-1:0] = bank. If w >= NUM_WIN the write is ignored.
  - 0x9D00: ctrl. bit0 = nvram_wr_en, bit1 = ram_wp (1 = writes blocked), bit3 = immediate (bank writes go to shadow and live in the same cycle). bit2 is defined under Optional Feature.
  - 0x9E00: soft-reset trigger; data is ignored.
- Live bank value:
  - If bank_ena=0: all-ones bank, ROM mode.
  - Otherwise: live[w].
- Address mapping, combinational. The selected window is the lowest w with vic_blk_sel[w]=1.
  - ROM: {2'b00, bank, vic_addr[12:0]}.
  - Cart RAM: {2'b01, zero pad, w[1:0], vic_addr[12:0]}.
  - Else, if mc_nvram_sel=1: {2'b10, zero pad, vic_addr[12:0]}.
  - Else: 0.
- mc_nvram_sel = reset_n & (vic_ram123_sel | vic_io2_sel | vic_io3_sel).
- mc_wr_n is low only when all hold: reset_n=1, vic_wr_n=0, and either (window selected in RAM mode and ram_wp=0) or (mc_nvram_sel=1 and nvram_wr_en=1). ROM writes are never passed.
- Sequencer FSM:
  - IDLE: wstb to 0x9E00 commits live <= shadow for all windows, sets bank_ena=1, then goes to PULSE.
  - PULSE: mc_soft_reset=1 for exactly RESET_PULSE cycles, starting the cycle after the strobe; then goes to HOLDOFF, or straight to IDLE if HOLDOFF=0.
  - HOLDOFF: lasts HOLDOFF cycles, then goes to IDLE.
  - mc_busy=1 in PULSE and HOLDOFF.
  - All register writes, including the trigger, are ignored while mc_busy=1.
- Simultaneous events: a strobe cannot hit two registers, because the decode is exclusive.
- reset_n low mid-PULSE: the FSM goes to IDLE, mc_soft_reset drops on that edge, and bank_ena is cleared.

Optional Feature:
MAPPER_LOCK_EN
- Defined: ctrl bit2 = lock. Once written as 1, every register write and the 0x9E00 trigger is ignored until reset_n. A write that sets lock still applies its other ctrl bits in that same write.
- Undefined: ctrl bit2 is not stored, and writes are never locked.

Decomposition:
- Package banked_cart_pkg:
  - region constants REG_ROM=2'b00, REG_RAM=2'b01, REG_NVRAM=2'b10.
  - register offsets (bank base 6'h00, ctrl 6'h10, trigger 6'h20 on vic_addr[9:4]).
  - ctrl bit indices.
  - FSM state enum {IDLE, PULSE, HOLDOFF}.
- Sub-module soft_reset_seq: the FSM plus one counter sized to max(RESET_PULSE, HOLDOFF). Inputs: trigger. Outputs: commit pulse, mc_soft_reset, mc_busy.

Test Plan:
1. Read-only check after reset, no writes; vic_blk_sel=4'b1000, vic_addr=16'hA123 -> mc_addr = {2'b00, 7'h7F, 13'h0123}; mc_wr_n=1 when CPU writes.
2. Staged commit: write 8'h05 to 0x9C10; window1 read still maps to bank 7F. Write 0x9E00 -> mc_soft_reset high for exactly 32 cycles, mc_busy high for 48; window1 then maps to bank 05.
3. RAM mode and write protect:
   - Bank w2 = 8'h80 plus commit; write at 0x6010 -> mc_addr = {2'b01, 5'b0, 2'd2, 13'h0010}, mc_wr_n=0.
   - Set ctrl=8'h02 -> mc_wr_n=1.
4. Long write strobe and busy guard: CPU write to 0x9E00 held 10 cycles -> one sequence. A bank write during HOLDOFF -> shadow unchanged.
5. Mid-pulse reset: reset_n low at pulse cycle 5 -> mc_soft_reset=0 and mc_busy=0 on the next edge; banks return to 7F.
6. Lock (MAPPER_LOCK_EN defined): ctrl=8'h04 -> a later 0x9E00 write produces no pulse and 0x9C00 writes do not reach the shadow register; reset_n clears the lock. With the macro undefined, the same writes still take effect.
